// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with a per-register busy
// scoreboard and optional same-cycle write-to-read forwarding.
module reg_file_sb #(
    parameter int              DATA_W    = 16,
    parameter int              NUM_REGS  = 8,
    parameter int              NUM_RD    = 2,
    parameter int              BYPASS    = 1,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    localparam int             AW        = $clog2(NUM_REGS)
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     wr_en,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic                     iss_rdy,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     wr_err
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic                wr_err_q;

    // One-hot decodes; an out-of-range address decodes to all zeros,
    // which makes writes, issues and reads to it inert without extra checks.
    logic [NUM_REGS-1:0] wr_hit;
    logic [NUM_REGS-1:0] iss_hit;
    logic                iss_acc;

    // Decode write and issue addresses, derive issue acceptance
    always_comb begin
        wr_hit  = '0;
        iss_hit = '0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (wr_addr == AW'(r))
                wr_hit[r] = wr_en;
            if (iss_addr == AW'(r))
                iss_hit[r] = 1'b1;
        end
        // A writeback retiring the destination frees it in the same cycle
        iss_rdy = |(iss_hit & (~busy_q | wr_hit));
        iss_acc = iss_en & iss_rdy;
    end

    // Combinational read ports with optional forwarding of the write port
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) begin
                if (rd_addr[i*AW +: AW] == AW'(r)) begin
                    if (BYPASS != 0 && wr_hit[r]) begin
                        rd_data[i*DATA_W +: DATA_W] = wr_data;
                        rd_busy[i]                  = 1'b0;
                    end else begin
                        rd_data[i*DATA_W +: DATA_W] = regs_q[r];
                        rd_busy[i]                  = busy_q[r];
                    end
                end
            end
        end
    end

    // Register storage, scoreboard update (set wins over clear) and sticky error
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                regs_q[r] <= RESET_VAL;
            busy_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < NUM_REGS; r++)
                if (wr_hit[r])
                    regs_q[r] <= wr_data;
            busy_q <= (busy_q & ~wr_hit) | (iss_hit & {NUM_REGS{iss_acc}});
            if (|(wr_hit & ~busy_q))
                wr_err_q <= 1'b1;
        end
    end

    assign busy_vec = busy_q;
    assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: three configurations (bypass, no bypass, 6 registers)
// driven with identical stimulus and checked against a behavioural model.
module tb_reg_file_sb;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset, wr_en, iss_en;
    logic [2:0]  wr_addr, iss_addr;
    logic [15:0] wr_data;
    logic [5:0]  rd_addr;

    logic [31:0] rd_data [3];
    logic [1:0]  rd_busy [3];
    logic        iss_rdy [3];
    logic        wr_err  [3];
    logic [7:0]  bv_a, bv_b;
    logic [5:0]  bv_c;
    logic [7:0]  obs_bv  [3];

    int checks = 0;
    int errors = 0;

    // Model state, one copy per configuration
    logic [15:0] m_regs [3][8];
    bit          m_busy [3][8];
    bit          m_err  [3];
    int          nregs  [3] = '{8, 8, 6};
    int          bp     [3] = '{1, 0, 1};

    reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(1)) u_dut (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data[0]), .rd_busy(rd_busy[0]),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_rdy(iss_rdy[0]),
        .busy_vec(bv_a), .wr_err(wr_err[0]));

    reg_file_sb #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(0)) u_nb (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data[1]), .rd_busy(rd_busy[1]),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_rdy(iss_rdy[1]),
        .busy_vec(bv_b), .wr_err(wr_err[1]));

    reg_file_sb #(.DATA_W(16), .NUM_REGS(6), .NUM_RD(2), .BYPASS(1)) u_six (
        .Clk(Clk), .Reset(Reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr(rd_addr), .rd_data(rd_data[2]), .rd_busy(rd_busy[2]),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_rdy(iss_rdy[2]),
        .busy_vec(bv_c), .wr_err(wr_err[2]));

    always_comb begin
        obs_bv[0] = bv_a;
        obs_bv[1] = bv_b;
        obs_bv[2] = {2'b00, bv_c};
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_rdy(input int k);
        if (int'(iss_addr) >= nregs[k]) return 1'b0;
        return !m_busy[k][iss_addr] || (wr_en && wr_addr == iss_addr);
    endfunction

    // Compare every output of every configuration against the model
    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            logic [7:0] ebv;
            for (int i = 0; i < 2; i++) begin
                logic [2:0]  ra;
                logic [15:0] ed;
                bit          eb, hit, inr;
                ra  = rd_addr[i*3 +: 3];
                inr = int'(ra) < nregs[k];
                hit = inr && bp[k] != 0 && wr_en && wr_addr == ra;
                ed  = !inr ? 16'h0000 : (hit ? wr_data : m_regs[k][ra]);
                eb  = inr && m_busy[k][ra] && !hit;
                chk($sformatf("cfg%0d rd_data%0d a%0d", k, i, ra), 32'(rd_data[k][i*16 +: 16]), 32'(ed));
                chk($sformatf("cfg%0d rd_busy%0d a%0d", k, i, ra), 32'(rd_busy[k][i]), 32'(eb));
            end
            ebv = '0;
            for (int r = 0; r < nregs[k]; r++) ebv[r] = m_busy[k][r];
            chk($sformatf("cfg%0d iss_rdy a%0d", k, iss_addr), 32'(iss_rdy[k]), 32'(model_rdy(k)));
            chk($sformatf("cfg%0d busy_vec", k), 32'(obs_bv[k]), 32'(ebv));
            chk($sformatf("cfg%0d wr_err", k), 32'(wr_err[k]), 32'(m_err[k]));
        end
    endtask

    // Advance the model by one clock edge using the inputs held across it
    task automatic model_edge();
        for (int k = 0; k < 3; k++) begin
            bit rdy;
            rdy = model_rdy(k);
            if (Reset) begin
                for (int r = 0; r < 8; r++) begin
                    m_regs[k][r] = 16'h0000;
                    m_busy[k][r] = 1'b0;
                end
                m_err[k] = 1'b0;
            end else begin
                if (wr_en && int'(wr_addr) < nregs[k]) begin
                    if (!m_busy[k][wr_addr]) m_err[k] = 1'b1;
                    m_regs[k][wr_addr] = wr_data;
                    m_busy[k][wr_addr] = 1'b0;
                end
                if (iss_en && rdy) m_busy[k][iss_addr] = 1'b1;
            end
        end
    endtask

    task automatic step(input logic rst, input logic we, input logic [2:0] wa,
                        input logic [15:0] wd, input logic ie, input logic [2:0] ia,
                        input logic [2:0] r0, input logic [2:0] r1);
        @(negedge Clk);
        Reset    = rst;
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        rd_addr  = {r1, r0};
        #1 check_all();
        @(posedge Clk);
        model_edge();
    endtask

    initial begin
        Reset = 1'b1; wr_en = 1'b0; iss_en = 1'b0;
        wr_addr = '0; iss_addr = '0; wr_data = '0; rd_addr = '0;
        @(posedge Clk);
        @(posedge Clk);
        model_edge();

        // Reset state on every register, both ports
        step(1, 0, 0, 16'h0, 0, 0, 0, 0);
        for (int r = 0; r < 8; r++) step(0, 0, 0, 16'h0, 0, 0, 3'(r), 3'(7 - r));

        // Issue R3, hazard, forwarded writeback, then cleared
        step(0, 0, 0, 16'h0,    1, 3, 3, 3);
        step(0, 0, 0, 16'h0,    0, 0, 3, 3);
        step(0, 1, 3, 16'hBEEF, 0, 0, 3, 3);
        step(0, 0, 0, 16'h0,    0, 0, 3, 3);

        // WAW stall on R5, then issue alongside writeback of R5
        step(0, 0, 0, 16'h0,    1, 5, 5, 5);
        step(0, 0, 0, 16'h0,    1, 5, 5, 5);
        step(0, 1, 5, 16'h1234, 1, 5, 5, 5);
        step(0, 0, 0, 16'h0,    0, 0, 5, 5);

        // Write to non-busy registers: sticky wr_err, bypass vs no bypass
        step(0, 1, 2, 16'h00FF, 0, 0, 2, 2);
        step(0, 0, 0, 16'h0,    0, 0, 2, 2);
        step(0, 1, 1, 16'hA5A5, 0, 0, 1, 1);
        step(0, 0, 0, 16'h0,    0, 0, 1, 1);

        // Out-of-range traffic for the 6-register build, then Reset overriding traffic
        step(0, 1, 7, 16'hFFFF, 1, 7, 7, 6);
        step(0, 1, 6, 16'h7777, 1, 6, 7, 6);
        step(0, 0, 0, 16'h0,    0, 0, 7, 6);
        step(0, 0, 0, 16'h0,    1, 4, 4, 4);
        step(1, 1, 4, 16'h1111, 1, 2, 4, 2);
        step(0, 0, 0, 16'h0,    0, 0, 4, 2);

        // Randomized traffic, writebacks biased toward busy registers
        for (int n = 0; n < 3000; n++) begin
            logic [2:0] wa;
            wa = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) begin
                for (int t = 0; t < 4; t++) begin
                    logic [2:0] c;
                    c = 3'($urandom_range(0, 7));
                    if (m_busy[0][c]) wa = c;
                end
            end
            step(($urandom_range(0, 99) == 0), 1'($urandom), wa, 16'($urandom),
                 1'($urandom), 3'($urandom_range(0, 7)),
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
